dram_line_ctrl: RTL and testbench

DRAM_LINE_CTRL -- requirements
Module: dram_line_ctrl

---
 rtl/dram_pkg.sv | 16 +
 rtl/sram.sv | 31 +++
 rtl/dram_line_ctrl.sv | 141 ++++++++++++++
 tb/tb_dram_line_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dram_pkg.sv
// dram_pkg: shared types and constants for the DRAM line controller.
//   state_t         - controller FSM states (IDLE, BUSY, ACK)
//   LINE_OFFSET_W   - byte-offset bits within a 32-byte line (ignored address bits)
//   DEFAULT_LATENCY - default accept-to-ack latency in cycles
package dram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int unsigned LINE_OFFSET_W   = 5;
  localparam int unsigned DEFAULT_LATENCY = 10;

endpackage

// File: rtl/sram.sv
// sram: single-port line storage, synchronous write, asynchronous read.
// Contents are not initialised.
// Ports:
//   clk     - clock, write on rising edge
//   i_we    - write enable
//   i_addr  - line index (read and write)
//   i_wdata - write data
//   o_rdata - read data for i_addr (combinational)
module sram #(
  parameter int addr_width = 9,
  parameter int data_width = 256,
  parameter int mem_size   = 512
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [addr_width-1:0] i_addr,
  input  logic [data_width-1:0] i_wdata,
  output logic [data_width-1:0] o_rdata
);

  logic [data_width-1:0] r_mem [mem_size];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dram_line_ctrl.sv
// dram_line_ctrl: fixed-latency line store emulating DRAM behind an L1 cache.
// A request (dram_cs) is accepted in IDLE, address/direction/data are captured,
// and dram_ack pulses for one cycle exactly dram_latency cycles after the accept
// edge. Reads present the stored line on dram_data_o from the ACK cycle until the
// next read's ACK; writes commit on the edge leaving ACK.
// Optional build macro: DRAM_PROTOCOL_CHECK_EN adds the sticky proto_err output.
// Ports:
//   clk         - clock
//   rst         - synchronous active-high reset
//   dram_addr   - line byte address (bits [4:0] ignored)
//   dram_cs     - request strobe, held until ack
//   dram_we     - 1 = write-back, 0 = fill
//   dram_ack    - one-cycle completion pulse
//   dram_data_i - write-back line
//   dram_data_o - fill line
//   proto_err   - (DRAM_PROTOCOL_CHECK_EN only) requester protocol violation, sticky
module dram_line_ctrl
  import dram_pkg::*;
#(
  parameter int addr_width     = 32,
  parameter int mem_data_width = 256,
  parameter int mem_lines      = 512,
  parameter int dram_latency   = int'(DEFAULT_LATENCY)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [addr_width-1:0]     dram_addr,
  input  logic                      dram_cs,
  input  logic                      dram_we,
  output logic                      dram_ack,
  input  logic [mem_data_width-1:0] dram_data_i,
  output logic [mem_data_width-1:0] dram_data_o
`ifdef DRAM_PROTOCOL_CHECK_EN
  ,
  output logic                      proto_err
`endif
);

  localparam int IDX_W = $clog2(mem_lines);
  // Largest counter value is dram_latency-2, which always fits in clog2(dram_latency) bits.
  localparam int CNT_W = (dram_latency > 2) ? $clog2(dram_latency) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(dram_latency - 2);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic [IDX_W-1:0]          r_idx;
  logic                      r_we;
  logic [mem_data_width-1:0] r_wdata;
  logic                      r_ack;
  logic [mem_data_width-1:0] r_rdata;

  logic                      w_sram_we;
  logic [mem_data_width-1:0] w_sram_rdata;
  logic                      w_unused_addr;

  // Only the line-index field is stored; the rest of the address is don't-care.
  assign w_unused_addr = ^dram_addr;

  // Commit on the edge leaving ACK; a reset in ACK suppresses the write.
  assign w_sram_we = (r_state == ST_ACK) && r_we && !rst;

  sram #(
    .addr_width (IDX_W),
    .data_width (mem_data_width),
    .mem_size   (mem_lines)
  ) u_sram (
    .clk     (clk),
    .i_we    (w_sram_we),
    .i_addr  (r_idx),
    .i_wdata (r_wdata),
    .o_rdata (w_sram_rdata)
  );

`ifdef DRAM_PROTOCOL_CHECK_EN
  logic [addr_width-1:0] r_addr;
  logic                  r_proto_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (dram_cs) begin
            r_state <= ST_BUSY;
            r_cnt   <= CNT_LOAD;
            r_idx   <= dram_addr[LINE_OFFSET_W +: IDX_W];
            r_we    <= dram_we;
            r_wdata <= dram_data_i;
`ifdef DRAM_PROTOCOL_CHECK_EN
            r_addr  <= dram_addr;
`endif
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state <= ST_ACK;
            r_ack   <= 1'b1;
            // Storage cannot change between accept and ACK exit, so sampling
            // here yields the line as of the ACK cycle.
            if (!r_we) begin
              r_rdata <= w_sram_rdata;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_ACK: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ack   <= 1'b0;
        end
      endcase
    end
  end

`ifdef DRAM_PROTOCOL_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (r_state == ST_BUSY &&
                 (!dram_cs || dram_addr != r_addr || dram_we != r_we)) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;
`endif

  assign dram_ack    = r_ack;
  assign dram_data_o = r_rdata;

endmodule

// File: tb/tb_dram_line_ctrl.sv
// tb_dram_line_ctrl: scoreboard bench for dram_line_ctrl.
// Stimulus pushes the expected completion (ack cycle, direction, data) into a
// queue; a monitor pops and compares on every ack. The reference model is a
// line-indexed associative array addressed by (addr / 32) % lines.
// Honours DRAM_PROTOCOL_CHECK_EN for the proto_err port.
module tb_dram_line_ctrl;

  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int LINES = 512;
  localparam int LAT   = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dram_cs = 1'b0;
  logic          dram_we = 1'b0;
  logic [AW-1:0] dram_addr = '0;
  logic [DW-1:0] dram_data_i = '0;
  logic          dram_ack;
  logic [DW-1:0] dram_data_o;
`ifdef DRAM_PROTOCOL_CHECK_EN
  logic          proto_err;
`endif

  dram_line_ctrl #(
    .addr_width     (AW),
    .mem_data_width (DW),
    .mem_lines      (LINES),
    .dram_latency   (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dram_addr   (dram_addr),
    .dram_cs     (dram_cs),
    .dram_we     (dram_we),
    .dram_ack    (dram_ack),
    .dram_data_i (dram_data_i),
    .dram_data_o (dram_data_o)
`ifdef DRAM_PROTOCOL_CHECK_EN
    ,
    .proto_err   (proto_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int            acc;
    bit            we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] model[int];
  logic [DW-1:0] last_rd = '0;
  bit            prev_ack = 1'b0;

  function automatic int line_of(input logic [AW-1:0] a);
    return int'((a / 32) % LINES);
  endfunction

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  task automatic check_vec(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compares every ack against the scoreboard and checks that the
  // fill output holds its last read value otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_rd  = '0;
        prev_ack = 1'b0;
      end else begin
        if (dram_ack) begin
          check_int("ack_single_cycle", int'(prev_ack), 0);
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ack at cycle %0d expected no ack", cyc);
          end else begin
            e = sb.pop_front();
            check_int("ack_latency", cyc, e.acc + LAT);
            if (!e.we) begin
              check_vec("read_data", dram_data_o, e.data);
              last_rd = e.data;
            end else begin
              check_vec("hold_on_write", dram_data_o, last_rd);
            end
          end
        end else begin
          check_vec("data_o_hold", dram_data_o, last_rd);
        end
        prev_ack = dram_ack;
      end
    end
  end

  // Drive a request; acc is the cycle whose closing edge samples dram_cs.
  task automatic launch(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input int acc, input bit track);
    exp_t e;
    dram_cs     = 1'b1;
    dram_we     = we;
    dram_addr   = addr;
    dram_data_i = data;
    if (track) begin
      e.acc  = acc;
      e.we   = we;
      e.data = we ? data : model[line_of(addr)];
      sb.push_back(e);
      if (we) model[line_of(addr)] = data;
    end
  endtask

  task automatic wait_ack();
    bit got = 1'b0;
    for (int i = 0; i < 4 * LAT; i++) begin
      @(negedge clk);
      if (dram_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL ack_timeout: got no ack within %0d cycles expected ack", 4 * LAT);
    end
  endtask

  // chain=1: called in the ack cycle of the previous request with dram_cs held,
  // so the DUT accepts at the end of the following idle cycle.
  task automatic do_txn(input bit we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                        input bit chain);
    if (!chain) begin
      @(negedge clk);
      #1 launch(we, addr, data, cyc, 1'b1);
    end else begin
      #1 launch(we, addr, data, cyc + 1, 1'b1);
    end
    wait_ack();
  endtask

  task automatic release_cs();
    #1 dram_cs = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got simulation timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] p, q, old_line, s, r;
    logic [AW-1:0] addrs[8];
    bit            nxt;

    repeat (3) @(negedge clk);
    check_int("reset_ack", int'(dram_ack), 0);
    check_vec("reset_data_o", dram_data_o, '0);
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("reset_proto_err", int'(proto_err), 0);
`endif
    #1 rst = 1'b0;

    // Write A5 pattern to 0x40 and read it back.
    do_txn(1'b1, 32'h0000_0040, {32{8'hA5}}, 1'b0); release_cs();
    do_txn(1'b0, 32'h0000_0040, '0, 1'b0); release_cs();

    // Address wrap modulo lines*32 bytes.
    p = rnd_line();
    do_txn(1'b1, 32'h0000_4020, p, 1'b0); release_cs();
    do_txn(1'b0, 32'h0000_0020, '0, 1'b0); release_cs();

    // Back-to-back write then read of the same line.
    q = rnd_line();
    do_txn(1'b1, 32'h0000_0100, q, 1'b0);
    do_txn(1'b0, 32'h0000_0100, '0, 1'b1); release_cs();

    // Low address bits ignored.
    r = rnd_line();
    do_txn(1'b1, 32'h0000_01DF, r, 1'b0); release_cs();
    do_txn(1'b0, 32'h0000_01C0, '0, 1'b0); release_cs();
    do_txn(1'b0, 32'h0000_01DF, '0, 1'b0); release_cs();

`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_clean", int'(proto_err), 0);
`endif

    // Inputs changed in BUSY cycle 3 must not affect the captured request.
    s = rnd_line();
    @(negedge clk);
    #1 launch(1'b1, 32'h0000_0200, s, cyc, 1'b1);
    repeat (3) @(negedge clk);
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_before_change", int'(proto_err), 0);
`endif
    #1 begin
      dram_addr   = 32'h0000_0040;
      dram_data_i = ~s;
    end
    wait_ack();
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_set", int'(proto_err), 1);
`endif
    release_cs();
    do_txn(1'b0, 32'h0000_0200, '0, 1'b0); release_cs();
    do_txn(1'b0, 32'h0000_0040, '0, 1'b0); release_cs();
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_sticky", int'(proto_err), 1);
`endif

    // Reset in BUSY cycle 5 of a write to 0x80 aborts it.
    old_line = rnd_line();
    do_txn(1'b1, 32'h0000_0080, old_line, 1'b0); release_cs();
    @(negedge clk);
    #1 launch(1'b1, 32'h0000_0080, ~old_line, cyc, 1'b0);
    repeat (5) @(negedge clk);
    #1 begin
      rst     = 1'b1;
      dram_cs = 1'b0;
    end
    @(negedge clk);
    check_int("abort_reset_ack", int'(dram_ack), 0);
    check_vec("abort_reset_data_o", dram_data_o, '0);
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_cleared", int'(proto_err), 0);
`endif
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    do_txn(1'b0, 32'h0000_0080, '0, 1'b0); release_cs();

    // Randomised traffic over 8 lines with varying upper/low address bits.
    for (int k = 0; k < 8; k++) begin
      addrs[k] = ($urandom() & 32'hFFFF_C000) | (32'($urandom_range(0, LINES - 1)) << 5)
               | 32'($urandom_range(0, 31));
      do_txn(1'b1, addrs[k], rnd_line(), 1'b0); release_cs();
    end
    nxt = 1'b0;
    for (int i = 0; i < 40; i++) begin
      logic [AW-1:0] a;
      a = addrs[$urandom_range(0, 7)];
      a = ($urandom() & 32'hFFFF_C000) | (a & 32'h0000_3FE0) | 32'($urandom_range(0, 31));
      do_txn(1'($urandom_range(0, 1)), a, rnd_line(), nxt);
      nxt = 1'($urandom_range(0, 1));
      if (!nxt) begin
        release_cs();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    release_cs();
    repeat (4) @(negedge clk);
    check_int("scoreboard_drained", sb.size(), 0);
`ifdef DRAM_PROTOCOL_CHECK_EN
    check_int("proto_err_final", int'(proto_err), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
